muldiv_seq: RTL and testbench

- Multi-cycle sequencer for RV32M multiply/divide in the execute stage.
- Accepts one operation from the ALU decode path and runs an iterative shift-add or restoring-divide datapath for 32 iterations.
- Holds the pipeline stalled while busy, then presents a one-cycle result for writeback.
- The execute stage instantiates it alongside the alu when opcode is RCC and funct7 is 0000001.

---
 rtl/muldiv_seq_pkg.sv | 39 +++
 rtl/muldiv_seq_if.sv | 31 +++
 rtl/muldiv_seq_step.sv | 51 +++++
 rtl/muldiv_seq.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   - funct3 codes for the eight M-extension operations
//   - MDCC: funct7 value selecting the M extension under the RCC opcode
//   - 2-bit FSM state encoding
//   - small helpers for operand classification
// Optional feature macro used by muldiv_seq: MULDIV_EARLY_OUT_EN.
package muldiv_seq_pkg;

   localparam logic [6:0] MDCC = 7'b0000001;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } m_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FIXUP = 2'b10,
      ST_DONE  = 2'b11
   } md_state_e;

   // rs1 is treated as signed for MULH, MULHSU, DIV, REM.
   function automatic logic rs1_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV, REM.
   function automatic logic rs2_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: execute-stage <-> multiply/divide sequencer bundle.
//   start  : M-extension op valid in execute this cycle   (master -> slave)
//   funct3 : operation select                             (master -> slave)
//   rs1    : operand A (dividend / multiplicand)          (master -> slave)
//   rs2    : operand B (divisor / multiplier)             (master -> slave)
//   flush  : squash the in-flight op                      (master -> slave)
//   stall  : freeze PC, decode and execute registers      (slave -> master)
//   done   : one-cycle result-valid pulse                 (slave -> master)
//   result : op result, held until next write             (slave -> master)
interface muldiv_seq_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, rs1, rs2, flush,
      input  stall, done, result
   );

   modport slave (
      input  start, funct3, rs1, rs2, flush,
      output stall, done, result
   );
endinterface

// File: rtl/muldiv_seq_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   div_mode : 0 = shift-add multiply, 1 = restoring divide
//   acc_in   : 64-bit accumulator ({hi, lo} / {remainder, quotient})
//   operand  : multiplicand (multiply) or divisor (divide) magnitude
//   acc_out  : accumulator after this iteration
module muldiv_step
   import muldiv_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic              div_mode,
   input  logic [2*XLEN-1:0] acc_in,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] acc_out
);

   logic [XLEN:0]   sum;
   logic [2*XLEN:0] sh;
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] diff;
   logic            unused_diff;

   // Multiply: add into the high half, keeping the carry for the shift.
   assign sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, operand};

   // Divide: the shifted partial remainder needs XLEN+1 bits, and the trial
   // subtract one more for the borrow.
   assign sh          = {acc_in, 1'b0};
   assign rem_sh      = sh[2*XLEN:XLEN];
   assign diff        = {1'b0, rem_sh} - {2'b00, operand};
   // A successful subtract always leaves diff below the divisor.
   assign unused_diff = diff[XLEN];

   always_comb begin
      acc_out = '0;
      if (div_mode) begin
         if (!diff[XLEN+1]) begin
            acc_out = {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
         end else begin
            acc_out = {rem_sh[XLEN-1:0], sh[XLEN-1:0]};
         end
      end else begin
         if (acc_in[0]) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
         end else begin
            acc_out = {1'b0, acc_in[2*XLEN-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer for the execute stage.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : muldiv_seq_if.slave (start, funct3, rs1, rs2, flush -> stall, done, result)
// An accepted op runs 32 iterations of muldiv_step, a sign/special-case fixup
// cycle, then pulses done for one cycle. stall is combinational.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply by zero finish directly from IDLE with 1-cycle latency.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_seq_if.slave  bus
);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   m_op_e             op_q;
   logic [XLEN-1:0]   opnd_q;
   logic [XLEN-1:0]   rs1_q;
   logic [XLEN-1:0]   result_q;
   logic [2*XLEN-1:0] acc_q;
   logic [2*XLEN-1:0] acc_step;
   logic              qneg_q, rneg_q, div0_q, ovf_q;

   // ---------------- accept-time operand conditioning ----------------
   logic              accept;
   logic              is_div_now;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div0_now, ovf_now;
   logic [2*XLEN-1:0] acc_init;
   logic [XLEN-1:0]   opnd_init;

   assign accept     = (state_q == ST_IDLE) && bus.start && !bus.flush;
   assign is_div_now = bus.funct3[2];
   assign a_neg      = rs1_signed(bus.funct3) && bus.rs1[XLEN-1];
   assign b_neg      = rs2_signed(bus.funct3) && bus.rs2[XLEN-1];
   assign a_mag      = a_neg ? ('0 - bus.rs1) : bus.rs1;
   assign b_mag      = b_neg ? ('0 - bus.rs2) : bus.rs2;
   assign div0_now   = is_div_now && (bus.rs2 == '0);
   assign ovf_now    = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                       (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);

   // Multiply iterates over the multiplier (rs2) in the low half; divide
   // shifts the dividend (rs1) out of the low half as quotient bits enter.
   assign acc_init  = is_div_now ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
   assign opnd_init = is_div_now ? b_mag : a_mag;

`ifdef MULDIV_EARLY_OUT_EN
   logic            early_now;
   logic [XLEN-1:0] early_result;

   assign early_now = div0_now || ovf_now ||
                      (!is_div_now && ((bus.rs1 == '0) || (bus.rs2 == '0)));

   always_comb begin
      early_result = '0;
      if (div0_now) begin
         early_result = bus.funct3[1] ? bus.rs1 : '1;
      end else if (ovf_now) begin
         early_result = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
   end
`endif

   // ---------------- iteration datapath ----------------
   muldiv_step #(.XLEN(XLEN)) u_step (
      .div_mode (op_q[2]),
      .acc_in   (acc_q),
      .operand  (opnd_q),
      .acc_out  (acc_step)
   );

   // ---------------- fixup: sign correction and output select ----------------
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo, rem;
   logic [XLEN-1:0]   fix_result;

   assign prod_s = qneg_q ? ('0 - acc_q) : acc_q;
   assign quo    = acc_q[XLEN-1:0];
   assign rem    = acc_q[2*XLEN-1:XLEN];

   always_comb begin
      fix_result = '0;
      unique case (op_q)
         F3_MUL: fix_result = prod_s[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_s[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU: begin
            if (div0_q)     fix_result = '1;
            else if (ovf_q) fix_result = {1'b1, {(XLEN-1){1'b0}}};
            else            fix_result = qneg_q ? ('0 - quo) : quo;
         end
         F3_REM, F3_REMU: begin
            if (div0_q)     fix_result = rs1_q;
            else if (ovf_q) fix_result = '0;
            else            fix_result = rneg_q ? ('0 - rem) : rem;
         end
         default: fix_result = '0;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      bus.stall = 1'b0;
      bus.done  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               bus.stall = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
               state_d = early_now ? ST_DONE : ST_BUSY;
`else
               state_d = ST_BUSY;
`endif
            end
         end
         ST_BUSY: begin
            bus.stall = 1'b1;
            if (bus.flush)         state_d = ST_IDLE;
            else if (cnt_q == '1)  state_d = ST_FIXUP;
         end
         ST_FIXUP: begin
            bus.stall = 1'b1;
            state_d   = bus.flush ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            bus.done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         op_q     <= F3_MUL;
         opnd_q   <= '0;
         rs1_q    <= '0;
         acc_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
      end else begin
         if (accept) begin
            cnt_q  <= '0;
            op_q   <= m_op_e'(bus.funct3);
            opnd_q <= opnd_init;
            rs1_q  <= bus.rs1;
            acc_q  <= acc_init;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            div0_q <= div0_now;
            ovf_q  <= ovf_now;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_now) result_q <= early_result;
`endif
         end else if (state_q == ST_BUSY && !bus.flush) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
         end else if (state_q == ST_FIXUP && !bus.flush) begin
            result_q <= fix_result;
         end
      end
   end

   assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven self-checking bench for muldiv_seq, plus
// hand-written flush and asynchronous-reset sequences.
module tb_muldiv_seq;

   logic clk;
   logic reset;

   muldiv_seq_if #(.XLEN(32)) bus ();

   muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          special;
      string       name;
   } vec_t;

   vec_t vecs[15];

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit special, input string name);
      int k;
      bit stall_bad;
      int exp_lat;
      exp_lat = (special && EARLY) ? 0 : 33;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = f3;
      bus.rs1    = a;
      bus.rs2    = b;
      #1;
      check({name, "_accept_stall"}, {31'd0, bus.stall}, 32'd1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      k = 0;
      stall_bad = 1'b0;
      while (!bus.done && k < 100) begin
         if (!bus.stall) stall_bad = 1'b1;
         @(posedge clk);
         #1;
         k++;
      end
      check({name, "_latency"}, k, exp_lat);
      check({name, "_wait_stall"}, {31'd0, stall_bad}, 32'd0);
      check({name, "_done_stall"}, {31'd0, bus.stall}, 32'd0);
      check({name, "_result"}, bus.result, exp);
      @(posedge clk);
      #1;
      check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      check({name, "_result_hold"}, bus.result, exp);
   endtask

   initial begin
      int done_seen;
      logic [31:0] prev_result;

      vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul"};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh"};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu"};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "mulhsu"};
      vecs[4]  = '{3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, "mulh_neg"};
      vecs[5]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, "div"};
      vecs[6]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "rem"};
      vecs[7]  = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_negb"};
      vecs[8]  = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "rem_negb"};
      vecs[9]  = '{3'b101, 32'd100,        32'd7,        32'd14,        1'b0, "divu"};
      vecs[10] = '{3'b111, 32'd100,        32'd7,        32'd2,         1'b0, "remu"};
      vecs[11] = '{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, "divu_by0"};
      vecs[12] = '{3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1, "rem_by0"};
      vecs[13] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf"};
      vecs[14] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf"};

      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.funct3 = 3'b000;
      bus.rs1    = '0;
      bus.rs2    = '0;
      bus.flush  = 1'b0;
      #2;
      check("reset_done",   {31'd0, bus.done},  32'd0);
      check("reset_stall",  {31'd0, bus.stall}, 32'd0);
      check("reset_result", bus.result,         32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special, vecs[i].name);
      end
      run_op(3'b000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b1, "mul_zero");

      // start together with flush in IDLE must not be accepted
      @(negedge clk);
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      bus.funct3 = 3'b000;
      bus.rs1    = 32'd9;
      bus.rs2    = 32'd9;
      #1;
      check("startflush_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      #1;
      check("startflush_idle", {31'd0, bus.stall}, 32'd0);

      // flush 10 cycles into BUSY
      prev_result = bus.result;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'b000;
      bus.rs1    = 32'h0001_2345;
      bus.rs2    = 32'h0000_6789;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      #1;
      check("flush_stall", {31'd0, bus.stall}, 32'd0);
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done) done_seen++;
         @(posedge clk);
         #1;
      end
      check("flush_no_done", done_seen, 0);
      check("flush_result",  bus.result, prev_result);
      run_op(3'b000, 32'd3, 32'd5, 32'd15, 1'b0, "mul_after_flush");

      // asynchronous reset between edges mid-BUSY
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'b100;
      bus.rs1    = 32'd1000;
      bus.rs2    = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("arst_done",   {31'd0, bus.done},  32'd0);
      check("arst_stall",  {31'd0, bus.stall}, 32'd0);
      check("arst_result", bus.result,         32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op(3'b100, 32'd20, 32'd4, 32'd5, 1'b0, "div_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no summary expected summary");
      $fatal(1);
   end

endmodule
